// File: rtl/basilisk_result_arbiter_pkg.sv
// Shared basilisk result types and constants used by the result writeback arbiter.
package basilisk_result_arbiter_pkg;

   localparam int unsigned BASILISK_COMPUTE_WIDTH  = 32;
   localparam int unsigned BASILISK_REG_ADDR_WIDTH = 5;

   // Memory, convert and compute lanes all write back through one port.
   localparam int unsigned BASILISK_RESULT_SOURCES = 3;

   typedef struct packed {
      logic [BASILISK_REG_ADDR_WIDTH-1:0] dest_reg_addr;
      logic [BASILISK_COMPUTE_WIDTH-1:0]  data;
   } basilisk_result_t;

   localparam int unsigned BASILISK_RESULT_WIDTH = $bits(basilisk_result_t);

   // Wraps an index that is known to be below 2*n back into 0..n-1.
   function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned n);
      return (idx >= n) ? (idx - n) : idx;
   endfunction

endpackage

// File: rtl/basilisk_result_arbiter_if.sv
// Valid/ready result stream bundle; N_LANES parallel streams share one bundle.
interface basilisk_result_arbiter_if
   import basilisk_result_arbiter_pkg::*;
#(
   parameter int unsigned N_LANES = 1
);

   logic [N_LANES-1:0]             valid;
   logic [N_LANES-1:0]             ready;
   basilisk_result_t [N_LANES-1:0] payload;

   modport master (output valid, output payload, input ready);
   modport slave  (input valid, input payload, output ready);

endinterface

// File: rtl/basilisk_result_arbiter_stage.sv
// Output stage: combinational pass-through or one-entry full-throughput register.
module basilisk_result_arbiter_stage #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned REGISTERED = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_ready,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data,
   input  logic             i_ready
);

   generate
      if (REGISTERED == 0) begin : g_pass
         logic w_unused;
         assign w_unused = clk ^ rst;
         assign o_valid  = i_valid;
         assign o_data   = i_data;
         assign o_ready  = i_ready;
      end else begin : g_reg
         logic             r_valid;
         logic [WIDTH-1:0] r_data;

         // Accept when empty or when the held entry leaves this same cycle.
         assign o_ready = !r_valid || i_ready;
         assign o_valid = r_valid;
         assign o_data  = r_data;

         always_ff @(posedge clk) begin
            if (rst) begin
               r_valid <= 1'b0;
            end else if (i_valid && o_ready) begin
               r_valid <= 1'b1;
            end else if (i_ready) begin
               r_valid <= 1'b0;
            end
         end

         always_ff @(posedge clk) begin
            if (i_valid && o_ready) begin
               r_data <= i_data;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/basilisk_result_arbiter.sv
// Round-robin arbiter merging NUM_REQUESTERS result streams onto one writeback stream.
module basilisk_result_arbiter
   import basilisk_result_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQUESTERS       = BASILISK_RESULT_SOURCES,
   parameter int unsigned OUTPUT_REGISTER_MODE = 1
) (
   input  logic                              clk,
   input  logic                              rst,
   basilisk_result_arbiter_if.slave          i_result_in,
   basilisk_result_arbiter_if.master         o_result_out,
   output logic [$clog2(NUM_REQUESTERS)-1:0] o_result_out_source
);

   localparam int unsigned SRC_W   = $clog2(NUM_REQUESTERS);
   localparam int unsigned STAGE_W = SRC_W + BASILISK_RESULT_WIDTH;

   logic [SRC_W-1:0]          r_ptr;
   logic [SRC_W-1:0]          w_cand;
   logic [SRC_W-1:0]          w_grant_idx;
   logic                      w_any_valid;
   logic                      w_req_valid;
   logic                      w_accept;
   logic                      w_load;
   logic                      w_out_valid;
   logic [NUM_REQUESTERS-1:0] w_ready;
   logic [STAGE_W-1:0]        w_stage_in;
   logic [STAGE_W-1:0]        w_stage_out;

   // Scan from the priority pointer upward with wrap; first valid requester wins.
   always_comb begin
      w_any_valid = 1'b0;
      w_grant_idx = r_ptr;
      w_cand      = r_ptr;
      for (int unsigned k = 0; k < NUM_REQUESTERS; k++) begin
         w_cand = SRC_W'(rr_wrap(32'(r_ptr) + k, NUM_REQUESTERS));
         if (!w_any_valid && i_result_in.valid[w_cand]) begin
            w_any_valid = 1'b1;
            w_grant_idx = w_cand;
         end
      end
   end

   assign w_req_valid = w_any_valid && !rst;
   assign w_load      = w_req_valid && w_accept;

   always_comb begin
      w_ready = '0;
      if (w_load) begin
         w_ready[w_grant_idx] = 1'b1;
      end
   end

   assign i_result_in.ready = w_ready;

   // Pointer moves past the winner only when its transfer actually completes.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (w_load) begin
         r_ptr <= SRC_W'(rr_wrap(32'(w_grant_idx) + 32'd1, NUM_REQUESTERS));
      end
   end

   assign w_stage_in = {w_grant_idx, i_result_in.payload[w_grant_idx]};

   basilisk_result_arbiter_stage #(
      .WIDTH      (STAGE_W),
      .REGISTERED (OUTPUT_REGISTER_MODE)
   ) u_out_stage (
      .clk     (clk),
      .rst     (rst),
      .i_valid (w_req_valid),
      .i_data  (w_stage_in),
      .o_ready (w_accept),
      .o_valid (w_out_valid),
      .o_data  (w_stage_out),
      .i_ready (o_result_out.ready[0])
   );

   assign o_result_out.valid[0]   = w_out_valid;
   assign o_result_out.payload[0] = basilisk_result_t'(w_stage_out[BASILISK_RESULT_WIDTH-1:0]);
   assign o_result_out_source     = w_stage_out[STAGE_W-1 -: SRC_W];

endmodule

// File: tb/tb_basilisk_result_arbiter.sv
// Bench for basilisk_result_arbiter: directed scenarios plus randomized traffic vs a reference model.
module tb_basilisk_result_arbiter;
   import basilisk_result_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   basilisk_result_arbiter_if #(.N_LANES(4)) in4  ();
   basilisk_result_arbiter_if #(.N_LANES(1)) out4 ();
   logic [1:0] src4;
   basilisk_result_arbiter_if #(.N_LANES(3)) in3  ();
   basilisk_result_arbiter_if #(.N_LANES(1)) out3 ();
   logic [1:0] src3;

   basilisk_result_arbiter #(.NUM_REQUESTERS(4), .OUTPUT_REGISTER_MODE(1)) u_dut (
      .clk(clk), .rst(rst), .i_result_in(in4), .o_result_out(out4), .o_result_out_source(src4));

   basilisk_result_arbiter #(.NUM_REQUESTERS(3), .OUTPUT_REGISTER_MODE(0)) u_dut0 (
      .clk(clk), .rst(rst), .i_result_in(in3), .o_result_out(out3), .o_result_out_source(src3));

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model for the N=4 registered instance: priority pointer plus one output slot.
   int               m_ptr   = 0;
   bit               m_valid = 1'b0;
   int               m_src   = 0;
   basilisk_result_t m_pay;

   typedef struct {
      int               src;
      basilisk_result_t pay;
   } sb_t;
   sb_t sb[$];
   int  wait_cnt[4];

   always @(negedge clk) begin
      int         win;
      int         g;
      bit         acc;
      bit         found;
      logic [3:0] exp_rdy;
      win = -1;
      if (!rst) begin
         for (int k = 0; k < 4; k++) begin
            if (win < 0 && in4.valid[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
         end
      end
      acc     = !m_valid || out4.ready[0];
      exp_rdy = (win >= 0 && acc) ? 4'(1 << win) : 4'd0;
      check("ready_vec", 64'(in4.ready), 64'(exp_rdy));
      check("out_valid", 64'(out4.valid[0]), 64'(m_valid));
      if (m_valid) begin
         check("out_src", 64'(src4), 64'(m_src));
         check("out_payload", 64'(out4.payload[0]), 64'(m_pay));
      end

      if (rst) begin
         sb.delete();
         for (int j = 0; j < 4; j++) wait_cnt[j] = 0;
      end else begin
         if (out4.valid[0] && out4.ready[0]) begin
            found = 1'b0;
            for (int i = 0; i < sb.size(); i++) begin
               if (!found && sb[i].src == int'(src4)) begin
                  found = 1'b1;
                  check("sb_payload", 64'(out4.payload[0]), 64'(sb[i].pay));
                  sb.delete(i);
               end
            end
            check("sb_present", 64'(found), 64'(1));
         end
         g = -1;
         for (int i = 0; i < 4; i++) if (in4.valid[i] && in4.ready[i]) g = i;
         if (g >= 0) begin
            sb.push_back('{g, in4.payload[g]});
            for (int j = 0; j < 4; j++) begin
               if (j == g) begin
                  wait_cnt[j] = 0;
               end else if (in4.valid[j]) begin
                  wait_cnt[j]++;
                  check("starvation", 64'(wait_cnt[j] <= 3), 64'(1));
               end
            end
         end
         for (int j = 0; j < 4; j++) if (!in4.valid[j]) wait_cnt[j] = 0;
      end

      if (rst) begin
         m_ptr   = 0;
         m_valid = 1'b0;
      end else if (win >= 0 && acc) begin
         m_valid = 1'b1;
         m_src   = win;
         m_pay   = in4.payload[win];
         m_ptr   = (win + 1) % 4;
      end else if (out4.ready[0]) begin
         m_valid = 1'b0;
      end
   end

   int               exp_seq[6] = '{0, 1, 2, 3, 0, 1};
   int               pulses;
   basilisk_result_t hold_exp;

   initial begin
      rst          = 1'b1;
      in4.valid    = '0;
      in4.payload  = '0;
      out4.ready   = 1'b1;
      in3.valid    = 3'b111;
      in3.payload  = '0;
      out3.ready   = 1'b1;
      repeat (3) step();
      #1;
      check("rst_ready4", 64'(in4.ready), 64'(0));
      check("rst_valid4", 64'(out4.valid[0]), 64'(0));
      check("rst_ready3", 64'(in3.ready), 64'(0));
      check("rst_valid3", 64'(out3.valid[0]), 64'(0));

      // All requesters valid: round-robin from pointer 0, one cycle of latency.
      rst       = 1'b0;
      in3.valid = '0;
      for (int i = 0; i < 4; i++) in4.payload[i] = '{dest_reg_addr: 5'(16 + i), data: 32'(i)};
      in4.valid = 4'hF;
      #1;
      check("first_ready", 64'(in4.ready), 64'(4'b0001));
      check("first_out_valid", 64'(out4.valid[0]), 64'(0));
      for (int c = 0; c < 6; c++) begin
         step();
         #1;
         check("rr_valid", 64'(out4.valid[0]), 64'(1));
         check("rr_src", 64'(src4), 64'(exp_seq[c]));
      end

      // Single active requester streams at full rate.
      in4.valid = 4'b0100;
      for (int c = 0; c < 3; c++) begin
         in4.payload[2] = '{dest_reg_addr: 5'(5 + c), data: $urandom};
         step();
         #1;
         check("single_valid", 64'(out4.valid[0]), 64'(1));
         check("single_src", 64'(src4), 64'(2));
         check("single_addr", 64'(out4.payload[0].dest_reg_addr), 64'(5 + c));
      end
      in4.valid = '0;
      step();
      #1;
      check("single_drained", 64'(out4.valid[0]), 64'(0));

      // Backpressure: one load, then output and pointer frozen.
      in4.valid  = 4'hF;
      out4.ready = 1'b0;
      pulses     = 0;
      for (int c = 0; c < 4; c++) begin
         for (int i = 0; i < 4; i++) in4.payload[i] = '{dest_reg_addr: 5'($urandom), data: $urandom};
         if (c == 0) hold_exp = in4.payload[3];
         #1;
         if (in4.ready != 4'd0) pulses++;
         step();
         #1;
         check("hold_src", 64'(src4), 64'(3));
         check("hold_payload", 64'(out4.payload[0]), 64'(hold_exp));
      end
      check("hold_pulses", 64'(pulses), 64'(1));
      out4.ready = 1'b1;
      #1;
      check("resume_ready", 64'(in4.ready), 64'(4'b0001));
      step();
      #1;
      check("resume_src0", 64'(src4), 64'(0));
      step();
      #1;
      check("resume_src1", 64'(src4), 64'(1));

      // Reset while the output register holds a result.
      out4.ready = 1'b0;
      step();
      rst = 1'b1;
      #1;
      check("midrst_ready", 64'(in4.ready), 64'(0));
      check("midrst_held", 64'(out4.valid[0]), 64'(1));
      step();
      rst = 1'b0;
      #1;
      check("midrst_cleared", 64'(out4.valid[0]), 64'(0));
      check("midrst_ptr0", 64'(in4.ready), 64'(4'b0001));
      in4.valid  = '0;
      out4.ready = 1'b1;

      // Combinational mode: same-cycle grant, pointer advanced to 1 first.
      for (int i = 0; i < 3; i++) in3.payload[i] = '{dest_reg_addr: 5'($urandom), data: $urandom};
      in3.valid = 3'b001;
      #1;
      check("m0_first_ready", 64'(in3.ready), 64'(3'b001));
      step();
      in3.valid = 3'b011;
      #1;
      check("m0_ready_p1", 64'(in3.ready), 64'(3'b010));
      check("m0_valid", 64'(out3.valid[0]), 64'(1));
      check("m0_src_p1", 64'(src3), 64'(1));
      check("m0_payload", 64'(out3.payload[0]), 64'(in3.payload[1]));
      step();
      #1;
      check("m0_ready_p2", 64'(in3.ready), 64'(3'b001));
      check("m0_src_p2", 64'(src3), 64'(0));
      out3.ready = 1'b0;
      #1;
      check("m0_stall_ready", 64'(in3.ready), 64'(0));
      check("m0_stall_valid", 64'(out3.valid[0]), 64'(1));
      in3.valid  = '0;
      out3.ready = 1'b1;

      // Randomized traffic on the four-requester instance.
      for (int c = 0; c < 10000; c++) begin
         rst = ($urandom_range(0, 2999) == 0);
         for (int i = 0; i < 4; i++) begin
            in4.payload[i] = '{dest_reg_addr: 5'($urandom), data: $urandom};
            in4.valid[i]   = ($urandom_range(0, 3) != 0);
         end
         out4.ready = ($urandom_range(0, 9) < 7);
         step();
      end
      rst        = 1'b0;
      in4.valid  = '0;
      out4.ready = 1'b1;
      repeat (3) step();
      check("sb_drained", 64'(sb.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
